// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite widths and field types shared by master, slave and benches
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DATA_W/8-1:0] strb_t;
  typedef logic [1:0] resp_t;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite AW/W/B/AR/R channel bundle with master and slave views
interface axi_lite_if;
  axi_lite_pkg::addr_t awaddr;
  logic awvalid, awready;
  axi_lite_pkg::data_t wdata;
  axi_lite_pkg::strb_t wstrb;
  logic wvalid, wready;
  axi_lite_pkg::resp_t bresp;
  logic bvalid, bready;
  axi_lite_pkg::addr_t araddr;
  logic arvalid, arready;
  axi_lite_pkg::data_t rdata;
  axi_lite_pkg::resp_t rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: turns one valid/ready command at a time into an AXI4-Lite transaction
// and returns read data, response code and a saturating cycle count.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  addr_t            cmd_addr,
  input  data_t            cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output data_t            rsp_rdata,
  output resp_t            rsp_resp,
  output logic [CNT_W-1:0] rsp_cycles,
  axi_lite_if.master       m_axi_lite
);
  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, RSP} state_t;
  state_t state_q;
  addr_t addr_q;
  data_t wdata_q, rdata_q;
  resp_t resp_q;
  logic awvalid_q, wvalid_q, arvalid_q, rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic aw_hs, w_hs, busy;
  assign aw_hs = awvalid_q && m_axi_lite.awready;
  assign w_hs = wvalid_q && m_axi_lite.wready;
  assign busy = state_q inside {WREQ, WRESP, RREQ, RDATA};
  // areset gates cmd_ready so nothing is accepted while reset is held
  assign cmd_ready = state_q == IDLE && !areset;
  assign m_axi_lite.bready = state_q == WRESP;
  assign m_axi_lite.rready = state_q == RDATA;
  assign m_axi_lite.awaddr = addr_q;
  assign m_axi_lite.araddr = addr_q;
  assign m_axi_lite.wdata = wdata_q;
  assign m_axi_lite.wstrb = '1;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.wvalid = wvalid_q;
  assign m_axi_lite.arvalid = arvalid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign rsp_cycles = cnt_q;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (busy && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q <= cmd_addr;
          wdata_q <= cmd_wdata;
          cnt_q <= '0;
          awvalid_q <= cmd_write;
          wvalid_q <= cmd_write;
          arvalid_q <= !cmd_write;
          state_q <= cmd_write ? WREQ : RREQ;
        end
        WREQ: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs) wvalid_q <= 1'b0;
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) state_q <= WRESP;
        end
        WRESP: if (m_axi_lite.bvalid) begin
          resp_q <= m_axi_lite.bresp;
          rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q <= RSP;
        end
        RREQ: if (m_axi_lite.arready) begin
          arvalid_q <= 1'b0;
          state_q <= RDATA;
        end
        RDATA: if (m_axi_lite.rvalid) begin
          rdata_q <= m_axi_lite.rdata;
          resp_q <= m_axi_lite.rresp;
          rsp_valid_q <= 1'b1;
          state_q <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized scoreboard bench with a behavioural AXI4-Lite slave and memory
`timescale 1ns/1ps
module tb_axi_lite_master;
  import axi_lite_pkg::*;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 0, areset = 0;
  always #5 clk = ~clk;

  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic cmd_ready, rsp_valid;
  addr_t cmd_addr = '0;
  data_t cmd_wdata = '0, rsp_rdata;
  resp_t rsp_resp;
  logic [CNT_W-1:0] rsp_cycles;

  axi_lite_if bus();

  axi_lite_master #(.CNT_W(CNT_W)) dut (
    .aclk(clk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles), .m_axi_lite(bus)
  );

  typedef struct {
    logic  wr;
    data_t rdata;
    resp_t resp;
    int    fixed;
  } exp_t;

  int vectors = 0, errors = 0;
  int cyc = 0;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, rsp_hold = 0;
  resp_t s_resp;
  int acc_cyc = 0, issued = 0, done = 0;
  addr_t cur_addr;
  data_t cur_wdata;
  data_t ref_mem[addr_t];
  data_t slv_mem[addr_t];
  exp_t exp_q[$];
  int cyc_q[$];

  logic aw_done = 0, w_done = 0, ar_done = 0, b_fire = 0, r_fire = 0;
  addr_t aw_a, ar_a;
  data_t w_d;
  logic held = 0;
  int hold = 0;
  data_t sd;
  resp_t sr;
  logic [CNT_W-1:0] sc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t dflt(input addr_t a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endfunction

  // Slave: decides readies/valids at negedge so handshakes land on the following posedge
  initial begin
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(negedge clk);
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      if (areset) begin
        aw_done = 0; w_done = 0; ar_done = 0; b_fire = 0; r_fire = 0;
        bus.bvalid = 0; bus.rvalid = 0;
      end else begin
        if (b_fire) begin bus.bvalid = 0; b_fire = 0; aw_done = 0; w_done = 0; end
        if (r_fire) begin bus.rvalid = 0; r_fire = 0; ar_done = 0; end
        if (aw_done && w_done && !bus.bvalid) begin
          if (b_wait == 0) begin
            bus.bvalid = 1; bus.bresp = s_resp;
            if (s_resp == 2'b00) slv_mem[aw_a] = w_d;
          end else b_wait--;
        end
        if (ar_done && !bus.rvalid) begin
          if (r_wait == 0) begin
            bus.rvalid = 1; bus.rresp = s_resp;
            bus.rdata = slv_mem.exists(ar_a) ? slv_mem[ar_a] : dflt(ar_a);
          end else r_wait--;
        end
        if (aw_done) chk("awvalid_drop", bus.awvalid, 0);
        else if (bus.awvalid) begin
          chk("awaddr", bus.awaddr, cur_addr);
          if (aw_wait == 0) begin bus.awready = 1; aw_done = 1; aw_a = bus.awaddr; end
          else aw_wait--;
        end
        if (w_done) chk("wvalid_drop", bus.wvalid, 0);
        else if (bus.wvalid) begin
          chk("wdata", bus.wdata, cur_wdata);
          chk("wstrb", bus.wstrb, 4'hF);
          if (w_wait == 0) begin bus.wready = 1; w_done = 1; w_d = bus.wdata; end
          else w_wait--;
        end
        if (ar_done) chk("arvalid_drop", bus.arvalid, 0);
        else if (bus.arvalid) begin
          chk("araddr", bus.araddr, cur_addr);
          if (ar_wait == 0) begin bus.arready = 1; ar_done = 1; ar_a = bus.araddr; end
          else ar_wait--;
        end
        if (bus.bvalid && bus.bready && !b_fire) begin b_fire = 1; cyc_q.push_back(cyc + 1 - acc_cyc); end
        if (bus.rvalid && bus.rready && !r_fire) begin r_fire = 1; cyc_q.push_back(cyc + 1 - acc_cyc); end
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears, then watches it while held
  initial begin
    exp_t e;
    int m;
    forever begin
      @(negedge clk);
      if (areset) begin held = 0; rsp_ready = 0; end
      else if (rsp_valid) begin
        if (!held) begin
          held = 1; hold = rsp_hold; sd = rsp_rdata; sr = rsp_resp; sc = rsp_cycles;
          if (exp_q.size() == 0 || cyc_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_rsp: got rdata %0h resp %0h, expected no response", rsp_rdata, rsp_resp);
          end else begin
            e = exp_q.pop_front();
            m = cyc_q.pop_front();
            chk(e.wr ? "wr_rdata" : "rd_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_cycles", rsp_cycles, (m > CMAX) ? CMAX : m);
            if (e.fixed >= 0) begin
              chk("fixed_cycles", rsp_cycles, e.fixed);
              chk("rsp_latency", cyc - acc_cyc, e.fixed);
            end
          end
        end else begin
          chk("rdata_stable", rsp_rdata, sd);
          chk("resp_stable", rsp_resp, sr);
          chk("cycles_stable", rsp_cycles, sc);
          chk("cmd_ready_busy", cmd_ready, 0);
        end
        if (hold == 0) begin rsp_ready = 1; held = 0; done++; end
        else begin rsp_ready = 0; hold--; end
      end else rsp_ready = 0;
    end
  end

  task automatic run(input logic wr, input addr_t a, input data_t d, input resp_t rs,
                     input int daw, input int dw, input int db, input int dar, input int dr,
                     input int hd, input int fixed, input logic wait_done);
    exp_t e;
    int n;
    aw_wait = daw; w_wait = dw; b_wait = db; ar_wait = dar; r_wait = dr;
    s_resp = rs; rsp_hold = hd; cur_addr = a; cur_wdata = d;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc + 1;
    e.wr = wr; e.resp = rs; e.fixed = fixed;
    e.rdata = wr ? '0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    if (wr && rs == 2'b00) ref_mem[a] = d;
    exp_q.push_back(e);
    issued++;
    @(negedge clk);
    cmd_valid = 0;
    if (wait_done) begin
      n = 0;
      while (done != issued && n < 200) begin @(negedge clk); n++; end
      chk("rsp_timeout", done == issued, 1);
    end
  endtask

  initial begin
    int n;
    logic wr;
    addr_t a;
    #1 areset = 1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_bready", bus.bready, 0);
    repeat (3) @(posedge clk);
    #2 areset = 0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rsp_cycles", rsp_cycles, 0);
    chk("idle_rsp_rdata", rsp_rdata, 0);
    chk("idle_rsp_resp", rsp_resp, 0);

    run(1, 32'h10, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 2, 1);
    run(0, 32'h10, '0, 2'b00, 0, 0, 0, 0, 0, 0, 2, 1);
    run(0, 32'h10, '0, 2'b00, 0, 0, 0, 3, 0, 0, -1, 1);
    run(1, 32'h20, 32'h1234_5678, 2'b00, 3, 0, 0, 0, 0, 0, -1, 1);
    run(1, 32'h24, 32'h0BAD_F00D, 2'b00, 0, 3, 0, 0, 0, 0, -1, 1);
    run(0, 32'h24, '0, 2'b00, 0, 0, 0, 0, 0, 10, -1, 1);
    run(0, 32'h30, '0, 2'b00, 0, 0, 0, 0, 20, 0, -1, 1);
    run(1, 32'h34, 32'hCAFE_0001, 2'b00, 0, 0, 20, 0, 0, 0, -1, 1);
    run(0, 32'h40, '0, 2'b10, 0, 0, 0, 0, 0, 0, -1, 1);

    run(0, 32'h80, '0, 2'b00, 0, 0, 0, 0, 15, 0, -1, 0);
    n = 0;
    while (!bus.rready && n < 50) begin @(negedge clk); n++; end
    chk("reach_rdata", bus.rready, 1);
    @(posedge clk);
    #2 areset = 1;
    #1;
    chk("arst_rready", bus.rready, 0);
    chk("arst_arvalid", bus.arvalid, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    cyc_q.delete();
    issued = done;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 areset = 0;
    run(0, 32'h10, '0, 2'b00, 0, 0, 0, 0, 0, 0, 2, 1);

    for (int i = 0; i < 8; i++)
      run(i % 2 == 0, 32'h100 + 32'(4 * (i / 2)), $urandom, 2'b00, 0, 0, 0, 0, 0, 0, 2, 1);

    for (int i = 0; i < 60; i++) begin
      wr = $urandom_range(0, 1) == 1;
      a = 32'h200 + 32'(4 * $urandom_range(0, 15));
      run(wr, a, $urandom, ($urandom_range(0, 4) == 0) ? resp_t'($urandom_range(1, 3)) : 2'b00,
          $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 6),
          $urandom_range(0, 5), $urandom_range(0, 12), $urandom_range(0, 3), -1, 1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
